// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: alignment-stage state and parcel classification.
package riscv_pkg;

   typedef enum logic [1:0] {
      ALIGNED   = 2'd0,
      UNALIGNED = 2'd1,
      HOLD      = 2'd2
   } align_state_type;

   // Parcel is RVC unless its low two bits are 2'b11; the OR keeps every bit in use.
   function automatic logic is_compressed(input logic [15:0] parcel);
      return !(&(parcel | 16'hFFFC));
   endfunction

endpackage

// File: rtl/riscv_ifu_align_if.sv
// Fetch-port, redirect and decode-side handshake bundle around the alignment stage.
interface riscv_ifu_align_if;

   logic        fetch_vld;
   logic        fetch_rdy;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_data;
   logic        flush;
   logic [31:0] flush_addr;
   logic        ifu_rdy;
   logic        ifu_vld;
   logic [31:0] ifu_addr;
   logic [31:0] ifu_data;

   modport master (
      output fetch_vld, fetch_addr, fetch_data, flush, flush_addr, ifu_rdy,
      input  fetch_rdy, ifu_vld, ifu_addr, ifu_data
   );

   modport slave (
      input  fetch_vld, fetch_addr, fetch_data, flush, flush_addr, ifu_rdy,
      output fetch_rdy, ifu_vld, ifu_addr, ifu_data
   );

endinterface

// File: rtl/riscv_ifu_align.sv
// Splits word-aligned fetch beats into 16/32-bit instructions, one per cycle,
// joining 32-bit instructions that straddle a word boundary.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ALIGNED   | next instruction starts at offset 0 of the expected word
// UNALIGNED | next instruction starts at offset 2, nothing held
// HOLD      | hold_q holds the first parcel of the next instruction
module riscv_ifu_align
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic            clock,
   input  logic            reset,
   riscv_ifu_align_if.slave bus
);

   localparam logic [31:0]     RESET_WORD  = {RESET_ADDR[31:2], 2'b00};
   localparam align_state_type RESET_STATE = RESET_ADDR[1] ? UNALIGNED : ALIGNED;

   align_state_type state_q, state_d;
   logic [15:0]     hold_q, hold_d;
   logic [31:0]     hold_addr_q, hold_addr_d;
   logic [31:0]     exp_addr_q, exp_addr_d;
   logic            vld_q, vld_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     data_q, data_d;

   logic            adv;
   logic            hold_ready;
   logic            fetch_rdy;
   logic            useful;
   logic            emit;
   logic [31:0]     emit_addr;
   logic [31:0]     emit_data;
   logic [31:0]     word;
   logic [31:0]     beat_addr;

   logic            unused_flush_lsb;
   assign unused_flush_lsb = bus.flush_addr[0];

   assign word      = bus.fetch_data;
   assign beat_addr = bus.fetch_addr;

   always_comb begin
      adv        = !vld_q || bus.ifu_rdy;
      hold_ready = (state_q == HOLD) && is_compressed(hold_q);
      fetch_rdy  = !reset && adv && !hold_ready;
      // A beat taken in a flush cycle or off the expected stream is just dropped.
      useful     = bus.fetch_vld && fetch_rdy && !bus.flush &&
                   (beat_addr == exp_addr_q);
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_addr_d = hold_addr_q;
      exp_addr_d  = exp_addr_q;
      vld_d       = vld_q;
      addr_d      = addr_q;
      data_d      = data_q;
      emit        = 1'b0;
      emit_addr   = addr_q;
      emit_data   = data_q;

      if (bus.flush) begin
         vld_d       = 1'b0;
         hold_d      = 16'h0000;
         hold_addr_d = 32'h0000_0000;
         exp_addr_d  = {bus.flush_addr[31:2], 2'b00};
         state_d     = bus.flush_addr[1] ? UNALIGNED : ALIGNED;
      end else if (adv) begin
         unique case (state_q)
            ALIGNED: begin
               if (useful) begin
                  exp_addr_d = exp_addr_q + 32'd4;
                  emit       = 1'b1;
                  emit_addr  = beat_addr;
                  if (is_compressed(word[15:0])) begin
                     emit_data   = {16'h0000, word[15:0]};
                     hold_d      = word[31:16];
                     hold_addr_d = beat_addr + 32'd2;
                     state_d     = HOLD;
                  end else begin
                     emit_data = word;
                  end
               end
            end
            UNALIGNED: begin
               if (useful) begin
                  exp_addr_d = exp_addr_q + 32'd4;
                  if (is_compressed(word[31:16])) begin
                     emit      = 1'b1;
                     emit_addr = beat_addr + 32'd2;
                     emit_data = {16'h0000, word[31:16]};
                     state_d   = ALIGNED;
                  end else begin
                     hold_d      = word[31:16];
                     hold_addr_d = beat_addr + 32'd2;
                     state_d     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (hold_ready) begin
                  emit      = 1'b1;
                  emit_addr = hold_addr_q;
                  emit_data = {16'h0000, hold_q};
                  state_d   = ALIGNED;
               end else if (useful) begin
                  // Straddle: upper half comes from the new word, next parcel is held.
                  exp_addr_d  = exp_addr_q + 32'd4;
                  emit        = 1'b1;
                  emit_addr   = hold_addr_q;
                  emit_data   = {word[15:0], hold_q};
                  hold_d      = word[31:16];
                  hold_addr_d = beat_addr + 32'd2;
               end
            end
            default: begin
               state_d = ALIGNED;
            end
         endcase

         vld_d = emit;
         if (emit) begin
            addr_d = emit_addr;
            data_d = emit_data;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RESET_STATE;
         hold_q      <= 16'h0000;
         hold_addr_q <= 32'h0000_0000;
         exp_addr_q  <= RESET_WORD;
         vld_q       <= 1'b0;
         addr_q      <= 32'h0000_0000;
         data_q      <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_addr_q <= hold_addr_d;
         exp_addr_q  <= exp_addr_d;
         vld_q       <= vld_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign bus.fetch_rdy = fetch_rdy;
   assign bus.ifu_vld   = vld_q;
   assign bus.ifu_addr  = addr_q;
   assign bus.ifu_data  = data_q;

endmodule

// File: tb/tb_riscv_ifu_align.sv
// Directed per-cycle vector table for the alignment stage plus an async-reset sequence.
module tb_riscv_ifu_align;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   riscv_ifu_align_if bus ();

   riscv_ifu_align #(.RESET_ADDR(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        fv;
      logic [31:0] fa;
      logic [31:0] fd;
      logic        fl;
      logic [31:0] fla;
      logic        ir;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_addr;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void add(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                               input logic fl, input logic [31:0] fla, input logic ir,
                               input logic e_rdy, input logic e_vld,
                               input logic [31:0] e_addr, input logic [31:0] e_data);
      vec_t v;
      v.fv = fv; v.fa = fa; v.fd = fd; v.fl = fl; v.fla = fla; v.ir = ir;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_addr = e_addr; v.e_data = e_data;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                        input logic fl, input logic [31:0] fla, input logic ir);
      bus.fetch_vld  = fv;
      bus.fetch_addr = fa;
      bus.fetch_data = fd;
      bus.flush      = fl;
      bus.flush_addr = fla;
      bus.ifu_rdy    = ir;
   endtask

   // Called just after a rising edge; samples at the falling edge, returns after the next rise.
   task automatic apply_vec(input vec_t v, input int idx);
      drive(v.fv, v.fa, v.fd, v.fl, v.fla, v.ir);
      @(negedge clock);
      chk($sformatf("row%0d fetch_rdy", idx), {31'd0, bus.fetch_rdy}, {31'd0, v.e_rdy});
      chk($sformatf("row%0d ifu_vld", idx), {31'd0, bus.ifu_vld}, {31'd0, v.e_vld});
      if (v.e_vld) begin
         chk($sformatf("row%0d ifu_addr", idx), bus.ifu_addr, v.e_addr);
         chk($sformatf("row%0d ifu_data", idx), bus.ifu_data, v.e_data);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

      //   fv  fetch_addr     fetch_data     fl  flush_addr     ir  rdy vld  ifu_addr       ifu_data
      // two 32-bit instructions back to back
      add(1, 32'h0000_0000, 32'h0000_0013, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0004, 32'h0010_0093, 0, 32'h0,          1,  1, 1, 32'h0000_0000, 32'h0000_0013);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0004, 32'h0010_0093);
      // two RVC in one word
      add(0, 32'h0,          32'h0,          1, 32'h0000_0000, 1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0000, 32'h4501_4505, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0004, 32'h0000_0013, 0, 32'h0,          1,  0, 1, 32'h0000_0000, 32'h0000_4505);
      add(1, 32'h0000_0004, 32'h0000_0013, 0, 32'h0,          1,  1, 1, 32'h0000_0002, 32'h0000_4501);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0004, 32'h0000_0013);
      // RVC, straddling 32-bit, trailing RVC
      add(0, 32'h0,          32'h0,          1, 32'h0000_0000, 1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0000, 32'h0013_4505, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0004, 32'h1234_0000, 0, 32'h0,          1,  1, 1, 32'h0000_0000, 32'h0000_4505);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  0, 1, 32'h0000_0002, 32'h0000_0013);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0006, 32'h0000_1234);
      // flush to 0x102 with stale beats at 0x0FC
      add(1, 32'h0000_00FC, 32'h1111_1111, 1, 32'h0000_0102, 1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_00FC, 32'h2222_2222, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0100, 32'h4505_1111, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0102, 32'h0000_4505);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      // decode stall for 3 cycles with an instruction pending
      add(1, 32'h0000_0104, 32'h0020_0113, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0108, 32'h0030_0193, 0, 32'h0,          0,  0, 1, 32'h0000_0104, 32'h0020_0113);
      add(1, 32'h0000_0108, 32'h0030_0193, 0, 32'h0,          0,  0, 1, 32'h0000_0104, 32'h0020_0113);
      add(1, 32'h0000_0108, 32'h0030_0193, 0, 32'h0,          0,  0, 1, 32'h0000_0104, 32'h0020_0113);
      add(1, 32'h0000_0108, 32'h0030_0193, 0, 32'h0,          1,  1, 1, 32'h0000_0104, 32'h0020_0113);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0108, 32'h0030_0193);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      // straddle across the top of the address space
      add(0, 32'h0,          32'h0,          1, 32'hFFFF_FFFE, 1,  1, 0, 32'h0,          32'h0);
      add(1, 32'hFFFF_FFFC, 32'h0093_5555, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(1, 32'h0000_0000, 32'hAAAA_0010, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  0, 1, 32'hFFFF_FFFE, 32'h0010_0093);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 1, 32'h0000_0002, 32'h0000_AAAA);
      add(0, 32'h0,          32'h0,          0, 32'h0,          1,  1, 0, 32'h0,          32'h0);

      // reset values
      repeat (2) @(posedge clock);
      #1;
      chk("reset ifu_vld", {31'd0, bus.ifu_vld}, 32'd0);
      chk("reset ifu_addr", bus.ifu_addr, 32'd0);
      chk("reset ifu_data", bus.ifu_data, 32'd0);
      chk("reset fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(vecs[i], i);
      end

      // async reset in the middle of a straddle
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
      @(posedge clock); #1;
      drive(1'b1, 32'h0, 32'h0013_4505, 1'b0, 32'h0, 1'b1);
      @(posedge clock); #1;
      drive(1'b1, 32'h4, 32'h1234_0000, 1'b0, 32'h0, 1'b1);
      chk("pre-reset ifu_vld", {31'd0, bus.ifu_vld}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset ifu_vld", {31'd0, bus.ifu_vld}, 32'd0);
      chk("async reset ifu_addr", bus.ifu_addr, 32'd0);
      chk("async reset ifu_data", bus.ifu_data, 32'd0);
      chk("async reset fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
      @(negedge clock);
      chk("post-reset fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd1);
      @(posedge clock); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      @(negedge clock);
      chk("post-reset ifu_vld", {31'd0, bus.ifu_vld}, 32'd1);
      chk("post-reset ifu_addr", bus.ifu_addr, 32'h0000_0000);
      chk("post-reset ifu_data", bus.ifu_data, 32'h0000_0013);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_ifu_align.md
# riscv_ifu_align

Instruction alignment stage between the fetch memory port and the decode stage. It accepts word-aligned 32-bit fetch beats and extracts 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It presents one instruction per cycle on the `ifu_vld`/`ifu_addr`/`ifu_data` interface consumed by `riscv_idu`. It also handles redirects (flushes) to any halfword address.

## Interface
Parameters:
- `RESET_ADDR`, default `32'h0000_0000`: first expected fetch address after reset (halfword aligned).

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_vld` in 1: fetch beat valid.
- `fetch_rdy` out 1: beat accepted when `fetch_vld && fetch_rdy`.
- `fetch_addr` in 32: beat word address; bits [1:0] are always 0.
- `fetch_data` in 32: beat data, little-endian halfwords.
- `flush` in 1: redirect pulse.
- `flush_addr` in 32: redirect target; bit 0 is ignored.
- `ifu_rdy` in 1: downstream accepts; tied 1 while decode has no stall.
- `ifu_vld` out 1: instruction valid.
- `ifu_addr` out 32: instruction address.
- `ifu_data` out 32: instruction; an RVC instruction is zero-extended as `{16'h0, c}`.

## Operation
- An instruction is compressed when bits [1:0] != 2'b11. `16'h0000` is passed through unchanged; decode flags it.
- Output register advance: `adv = !ifu_vld || ifu_rdy`. Nothing is consumed or emitted when `adv` is 0.
- `exp_addr` holds the next expected word address. An accepted beat is useful only when `fetch_addr == exp_addr`; otherwise it is consumed and discarded (`fetch_rdy = 1`, no emit, no state change).
- Each useful beat advances `exp_addr` by 4.
- Hold register: `h[15:0]`, `H[31:0]`.
- States:
  - ALIGNED (next instruction at word offset 0).
  - UNALIGNED (next instruction at offset 2 of the next word, nothing held).
  - HOLD (`h` holds the start of the next instruction).
- ALIGNED + useful beat w at A:
  - If w[1:0] != 11: emit w[15:0] @A; set h = w[31:16], H = A+2; go to HOLD.
  - Otherwise: emit w @A; stay in ALIGNED.
- UNALIGNED + useful beat w at A:
  - If w[17:16] != 11: emit w[31:16] @A+2; go to ALIGNED.
  - Otherwise: set h = w[31:16], H = A+2; go to HOLD with no emit.
- HOLD with h[1:0] != 11: `fetch_rdy = 0`; emit h @H when `adv`; go to ALIGNED. No beat is needed.
- HOLD with h[1:0] == 11 + useful beat w at A: emit {w[15:0], h} @H; set h = w[31:16], H = A+2; stay in HOLD.
- `fetch_rdy` is combinational: `adv && !(state == HOLD && h[1:0] != 11)`.
- Flush has priority over everything in the same cycle:
  - `ifu_vld` is cleared next cycle and the hold is dropped.
  - The beat presented in the flush cycle is not consumed as useful.
  - `exp_addr = {flush_addr[31:2], 2'b00}`.
  - State becomes UNALIGNED if `flush_addr[1]`, else ALIGNED.
- Address arithmetic is modulo 2^32. A straddle at `32'hFFFF_FFFE` wraps the next beat to address 0.

## Timing
- Reset values:
  - `ifu_vld = 0`, `ifu_addr = 0`, `ifu_data = 0`.
  - State ALIGNED (UNALIGNED if `RESET_ADDR[1]`).
  - `exp_addr = {RESET_ADDR[31:2], 2'b00}`; `h` and `H` = 0.
- `fetch_rdy` is 0 while in reset.
- Latency: a useful beat accepted in cycle N produces `ifu_vld` in cycle N+1.
- A held RVC instruction is emitted in the first `adv` cycle after it was captured.
- Throughput:
  - One instruction per cycle.
  - Two RVC instructions in one word take 2 cycles and 1 beat.
- `ifu_vld`/`ifu_addr`/`ifu_data` hold stable while `ifu_vld && !ifu_rdy`.
- Reset asserted mid-operation: outputs return to their reset values asynchronously. No partial instruction survives.

## Structure
- `riscv_pkg` gains:
  - `align_state_type` (enum: ALIGNED, UNALIGNED, HOLD).
  - Function `is_compressed(logic [15:0])`.
- A single module with no sub-module. State, hold, `exp_addr` and the output register all live in one `always_ff` with asynchronous reset. Next-state logic is in one `always_comb`.

## Test plan
- Reset, then beats `0x00000013` @0 and `0x00100093` @4 -> `ifu_vld` cycles 1 and 2 with addresses 0 and 4, data unchanged.
- Beat `0x45014505` @0 -> cycle 1: data `0x00004505` @0; cycle 2: data `0x00004501` @2; `fetch_rdy = 0` in cycle 1.
- Beat `0x00134505` @0, then `0x12340000` @4 -> `0x00004505` @0, then `0x00000013` @2 (straddle), then `0x00001234` @6.
- Flush to `0x102` while the beat at `0x0FC` is stale -> the stale beat is discarded. Beat `0x4505xxxx` @`0x100` yields `0x00004505` @`0x102` only.
- `ifu_rdy = 0` for 3 cycles with an instruction pending -> outputs held, `fetch_rdy = 0`; the stream resumes intact.
- Assert `reset` mid-straddle, asynchronously -> `ifu_vld = 0` immediately. After release, the first instruction comes from `RESET_ADDR`.
